// File: rtl/fetch_memory_arbiter.sv
// fetch_memory_arbiter
//   Shares one external memory port between instruction fetch (IF) and the
//   load/store path (D). Data accesses win arbitration, but after
//   STARVE_LIMIT consecutive D grants with fetch waiting, fetch is forced.
//   One transaction at a time: request is held until mem_ack_i, then one
//   idle cycle passes before the next grant.
//
// Ports
//   clock_i, reset_i                 clock, synchronous active-high reset
//   if_read_i / if_address_i         fetch request and address
//   if_data_o / if_ready_o           fetched word, one-cycle ready pulse
//   d_read_i / d_write_i             data read / write request
//   d_address_i / d_write_data_i     data address and store data
//   d_data_o / d_ready_o             load data, one-cycle ready pulse
//   mem_request_o / mem_write_o      memory transaction strobe and direction
//   mem_address_o / mem_write_data_o latched transaction address and data
//   mem_data_i / mem_ack_i           memory read data and completion pulse
module fetch_memory_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  if_read_i,
  input  logic [ADDR_WIDTH-1:0] if_address_i,
  output logic [DATA_WIDTH-1:0] if_data_o,
  output logic                  if_ready_o,
  input  logic                  d_read_i,
  input  logic                  d_write_i,
  input  logic [ADDR_WIDTH-1:0] d_address_i,
  input  logic [DATA_WIDTH-1:0] d_write_data_i,
  output logic [DATA_WIDTH-1:0] d_data_o,
  output logic                  d_ready_o,
  output logic                  mem_request_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] starve_cnt;

  logic d_req, d_win, if_match;

  assign d_req    = d_read_i | d_write_i;
  // D wins unless fetch has already been passed over LIMIT times in a row
  assign d_win    = d_req && (starve_cnt < LIMIT);
  // a redirected fetch no longer matches the in-flight address
  assign if_match = (if_address_i == mem_address_o);

  // read data goes straight through; only meaningful with the ready pulse
  assign if_data_o = mem_data_i;
  assign d_data_o  = mem_data_i;

  // reset in the ack cycle suppresses the pulse: the transaction is abandoned
  assign d_ready_o  = mem_ack_i && (state == BUSY_D) && !reset_i;
  assign if_ready_o = mem_ack_i && (state == BUSY_IF) && if_read_i && if_match
                      && !reset_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state            <= IDLE;
      starve_cnt       <= '0;
      mem_request_o    <= 1'b0;
      mem_write_o      <= 1'b0;
      mem_address_o    <= '0;
      mem_write_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_win) begin
            state            <= BUSY_D;
            mem_request_o    <= 1'b1;
            mem_write_o      <= d_write_i;   // read+write together is a write
            mem_address_o    <= d_address_i;
            mem_write_data_o <= d_write_data_i;
            // count only grants that made a waiting fetch lose
            if (!if_read_i)
              starve_cnt <= '0;
            else if (starve_cnt < LIMIT)
              starve_cnt <= starve_cnt + 4'd1;
          end else if (if_read_i) begin
            state            <= BUSY_IF;
            mem_request_o    <= 1'b1;
            mem_write_o      <= 1'b0;
            mem_address_o    <= if_address_i;
            mem_write_data_o <= '0;
            starve_cnt       <= '0;
          end
        end
        BUSY_IF, BUSY_D: begin
          // no grant in the ack cycle: guarantees one idle cycle between requests
          if (mem_ack_i) begin
            state         <= IDLE;
            mem_request_o <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          mem_request_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_memory_arbiter.sv
module tb_fetch_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_read, d_read, d_write, mem_ack;
  logic [31:0] if_address, d_address, d_write_data, mem_data;
  logic [31:0] if_data, d_data, mem_address, mem_write_data;
  logic        if_ready, d_ready, mem_request, mem_write;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fetch_memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clock_i(clock), .reset_i(reset),
    .if_read_i(if_read), .if_address_i(if_address),
    .if_data_o(if_data), .if_ready_o(if_ready),
    .d_read_i(d_read), .d_write_i(d_write),
    .d_address_i(d_address), .d_write_data_i(d_write_data),
    .d_data_o(d_data), .d_ready_o(d_ready),
    .mem_request_o(mem_request), .mem_write_o(mem_write),
    .mem_address_o(mem_address), .mem_write_data_o(mem_write_data),
    .mem_data_i(mem_data), .mem_ack_i(mem_ack)
  );

  typedef struct {
    logic        rst, ifr;
    logic [31:0] ifa;
    logic        dr, dw;
    logic [31:0] da, dwd;
    logic        ack;
    logic [31:0] md;
    logic        e_req, e_w;
    logic [31:0] e_addr, e_wd;
    logic        e_ifr, e_dr;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic rst, logic ifr, logic [31:0] ifa,
                              logic dr, logic dw, logic [31:0] da, logic [31:0] dwd,
                              logic ack, logic [31:0] md,
                              logic e_req, logic e_w, logic [31:0] e_addr,
                              logic [31:0] e_wd, logic e_ifr, logic e_dr);
    vec_t v;
    v.rst = rst; v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.dw = dw; v.da = da;
    v.dwd = dwd; v.ack = ack; v.md = md; v.e_req = e_req; v.e_w = e_w;
    v.e_addr = e_addr; v.e_wd = e_wd; v.e_ifr = e_ifr; v.e_dr = e_dr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // bounded wait for mem_request; called at a negedge
  task automatic wait_req(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_request === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clock);
    end
    check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    bit exp_if;

    // rst ifr  ifa        dr dw da          dwd           ack md  | req w addr wd ifr dr
    vecs[0]  = mk(1,0,0,     0,0,0,0,            0,0,            0,0,0,0,0,0);
    vecs[1]  = mk(0,1,32'h100,0,0,0,0,           0,0,            0,0,0,0,0,0);
    vecs[2]  = mk(0,1,32'h100,0,0,0,0,           0,0,            1,0,32'h100,0,0,0);
    vecs[3]  = mk(0,1,32'h100,0,0,0,0,           0,0,            1,0,32'h100,0,0,0);
    vecs[4]  = mk(0,1,32'h100,0,0,0,0,           0,0,            1,0,32'h100,0,0,0);
    vecs[5]  = mk(0,1,32'h100,0,0,0,0,           1,32'hDEADBEEF, 1,0,32'h100,0,1,0);
    vecs[6]  = mk(0,0,0,     0,0,0,0,            0,0,            0,0,32'h100,0,0,0);
    vecs[7]  = mk(0,0,0,     0,0,0,0,            1,32'h11111111, 0,0,32'h100,0,0,0);
    vecs[8]  = mk(0,0,0,     0,0,0,0,            0,0,            0,0,32'h100,0,0,0);
    vecs[9]  = mk(0,1,32'h200,0,1,32'h400,32'h12345678, 0,0,     0,0,32'h100,0,0,0);
    vecs[10] = mk(0,1,32'h200,0,1,32'h400,32'h12345678, 0,0,     1,1,32'h400,32'h12345678,0,0);
    vecs[11] = mk(0,1,32'h200,0,1,32'h400,32'h12345678, 1,32'h0BADF00D, 1,1,32'h400,32'h12345678,0,1);
    vecs[12] = mk(0,1,32'h200,0,0,0,0,           0,0,            0,1,32'h400,32'h12345678,0,0);
    vecs[13] = mk(0,1,32'h200,0,0,0,0,           0,0,            1,0,32'h200,0,0,0);
    vecs[14] = mk(0,1,32'h200,0,0,0,0,           1,32'hCAFEF00D, 1,0,32'h200,0,1,0);
    vecs[15] = mk(0,0,0,     0,0,0,0,            0,0,            0,0,32'h200,0,0,0);

    reset = 1'b1; if_read = 0; d_read = 0; d_write = 0; mem_ack = 0;
    if_address = 0; d_address = 0; d_write_data = 0; mem_data = 0;
    repeat (2) @(posedge clock);

    foreach (vecs[i]) begin
      @(negedge clock);
      reset = vecs[i].rst; if_read = vecs[i].ifr; if_address = vecs[i].ifa;
      d_read = vecs[i].dr; d_write = vecs[i].dw; d_address = vecs[i].da;
      d_write_data = vecs[i].dwd; mem_ack = vecs[i].ack; mem_data = vecs[i].md;
      #1;
      check($sformatf("v%0d_req", i),   {31'd0, mem_request}, {31'd0, vecs[i].e_req});
      check($sformatf("v%0d_write", i), {31'd0, mem_write},   {31'd0, vecs[i].e_w});
      check($sformatf("v%0d_addr", i),  mem_address,          vecs[i].e_addr);
      check($sformatf("v%0d_wdata", i), mem_write_data,       vecs[i].e_wd);
      check($sformatf("v%0d_ifrdy", i), {31'd0, if_ready},    {31'd0, vecs[i].e_ifr});
      check($sformatf("v%0d_drdy", i),  {31'd0, d_ready},     {31'd0, vecs[i].e_dr});
      if (vecs[i].ack) begin
        check($sformatf("v%0d_ifdata", i), if_data, vecs[i].md);
        check($sformatf("v%0d_ddata", i),  d_data,  vecs[i].md);
      end
    end

    // starvation guard: D held continuously with IF waiting
    @(negedge clock);
    d_read = 1; d_address = 32'h2000; if_read = 1; if_address = 32'h1000; mem_ack = 0;
    for (int g = 0; g < 10; g++) begin
      wait_req($sformatf("starve%0d", g), ok);
      if (!ok) break;
      exp_if = (g == 4 || g == 9);
      check($sformatf("starve%0d_grant", g), mem_address, exp_if ? 32'h1000 : 32'h2000);
      mem_ack = 1; mem_data = 32'(g);
      #1;
      check($sformatf("starve%0d_ifrdy", g), {31'd0, if_ready}, {31'd0, exp_if});
      check($sformatf("starve%0d_drdy", g),  {31'd0, d_ready},  {31'd0, !exp_if});
      @(negedge clock);
      mem_ack = 0;
    end
    d_read = 0; if_read = 0;
    @(negedge clock);

    // fetch redirect before the ack
    if_read = 1; if_address = 32'h300;
    wait_req("redir_a", ok);
    check("redir_a_addr", mem_address, 32'h300);
    @(negedge clock);
    if_address = 32'h500;
    #1; mem_ack = 1; mem_data = 32'hAAAA0300;
    #1;
    check("redir_stale_ifrdy", {31'd0, if_ready}, 32'd0);
    @(negedge clock);
    mem_ack = 0;
    wait_req("redir_b", ok);
    check("redir_b_addr", mem_address, 32'h500);
    mem_ack = 1; mem_data = 32'hBBBB0500;
    #1;
    check("redir_b_ifrdy", {31'd0, if_ready}, 32'd1);
    check("redir_b_data", if_data, 32'hBBBB0500);
    @(negedge clock);
    mem_ack = 0; if_read = 0;
    @(negedge clock);

    // reset during BUSY_D, with ack in the reset cycle and a stale ack after
    d_read = 1; d_address = 32'h80;
    wait_req("rst_d", ok);
    reset = 1; d_read = 0; mem_ack = 1;
    #1;
    check("rst_cycle_drdy", {31'd0, d_ready}, 32'd0);
    @(negedge clock);
    reset = 0;
    #1;
    check("rst_after_req", {31'd0, mem_request}, 32'd0);
    check("rst_stale_drdy", {31'd0, d_ready}, 32'd0);
    @(negedge clock);
    mem_ack = 0;
    #1;
    check("rst_stale_ignored", {31'd0, mem_request}, 32'd0);
    d_read = 1; d_address = 32'h84;
    @(negedge clock);
    check("rst_regrant_req", {31'd0, mem_request}, 32'd1);
    check("rst_regrant_addr", mem_address, 32'h84);
    mem_ack = 1;
    #1;
    check("rst_regrant_drdy", {31'd0, d_ready}, 32'd1);
    @(negedge clock);
    mem_ack = 0; d_read = 0;
    @(negedge clock);

    // read and write both high is a write
    d_read = 1; d_write = 1; d_address = 32'h40; d_write_data = 32'h55AA55AA;
    wait_req("rw", ok);
    check("rw_write", {31'd0, mem_write}, 32'd1);
    check("rw_addr", mem_address, 32'h40);
    check("rw_wdata", mem_write_data, 32'h55AA55AA);
    mem_ack = 1;
    #1;
    check("rw_drdy", {31'd0, d_ready}, 32'd1);
    @(negedge clock);
    mem_ack = 0; d_read = 0; d_write = 0;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
